// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: word, RAM state, arbiter state
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request ports and RAM port seen by the memory arbiter
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   // slave: the arbiter itself; master: the caches and RAM around it
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates icache/dcache requests onto the single RAM port
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int D_STREAK = 4
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);

   arb_state_t    state;
   logic [SW-1:0] streak;
   word_t         lat_addr;
   word_t         lat_data;
   logic          lat_wr;

   logic d_req, i_force, access, i_abort, d_abort, i_ack, d_ack;

   always_comb begin
      d_req   = bus.dREN | bus.dWEN;
      i_force = bus.iREN && (streak == STREAK_MAX);
      access  = (bus.ramstate == ACCESS);
      // only reads may be abandoned; a latched write always runs to completion
      i_abort = (state == IGRANT) && !bus.iREN;
      d_abort = (state == DGRANT) && !lat_wr && !bus.dREN;
      i_ack   = (state == IGRANT) && !i_abort && access;
      d_ack   = (state == DGRANT) && !d_abort && access;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         streak   <= '0;
         lat_addr <= '0;
         lat_data <= '0;
         lat_wr   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (d_req && !i_force) begin
                  lat_addr <= bus.daddr;
                  lat_data <= bus.dstore;
                  lat_wr   <= bus.dWEN;
                  state    <= DGRANT;
                  if (!bus.iREN)
                     streak <= '0;
                  else if (streak != STREAK_MAX)
                     streak <= streak + 1'b1;
               end else if (bus.iREN) begin
                  lat_addr <= bus.iaddr;
                  lat_data <= '0;
                  lat_wr   <= 1'b0;
                  state    <= IGRANT;
                  streak   <= '0;
               end else begin
                  streak <= '0;
               end
            end
            IGRANT: if (i_abort || access) state <= IDLE;
            DGRANT: if (d_abort || access) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ramREN   = (state == IGRANT) || ((state == DGRANT) && !lat_wr);
      bus.ramWEN   = (state == DGRANT) && lat_wr;
      bus.ramaddr  = (state != IDLE) ? lat_addr : '0;
      bus.ramstore = ((state == DGRANT) && lat_wr) ? lat_data : '0;
      bus.iwait    = !i_ack;
      bus.dwait    = !d_ack;
      bus.iload    = i_ack ? bus.ramload : '0;
      bus.dload    = (d_ack && !lat_wr) ? bus.ramload : '0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM model and reference memory
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int DS = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   mem_arbiter_if bus();

   mem_arbiter #(.D_STREAK(DS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   bit [31:0] mem     [256];
   bit [31:0] ref_mem [256];
   int  lat = 1;
   bit  stall = 1'b0;
   bit  force_err = 1'b0;
   int  ram_cnt = 0;
   int  total = 0;
   int  bad = 0;

   // RAM: FREE when idle, BUSY for lat cycles of an access, then ACCESS
   always_comb begin
      if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = FREE;
      else if (force_err)              bus.ramstate = ERROR;
      else if (stall)                  bus.ramstate = BUSY;
      else if (ram_cnt >= lat)         bus.ramstate = ACCESS;
      else                             bus.ramstate = BUSY;
   end
   assign bus.ramload = mem[bus.ramaddr[7:0]];

   always @(posedge CLK) begin
      if (!(bus.ramREN || bus.ramWEN) || bus.ramstate == ACCESS) ram_cnt <= 0;
      else ram_cnt <= ram_cnt + 1;
      if (bus.ramWEN && bus.ramstate == ACCESS) mem[bus.ramaddr[7:0]] <= bus.ramstore;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // kind: 0 icache read, 1 dcache read, 2 dcache write
   task automatic do_txn(input int kind, input word_t a, input word_t dat, input bit scramble);
      bit    acked = 1'b0;
      bit    other_ok = 1'b1;
      word_t got = '0;
      if (kind == 0) begin
         bus.iREN = 1'b1; bus.iaddr = a;
      end else begin
         bus.dREN = (kind == 1); bus.dWEN = (kind == 2);
         bus.daddr = a; bus.dstore = dat;
      end
      for (int c = 0; c < 40 && !acked; c++) begin
         tick();
         if (c == 0) begin
            chk("grant_ren", bus.ramREN, (kind != 2));
            chk("grant_wen", bus.ramWEN, (kind == 2));
            chk("grant_addr", bus.ramaddr, a);
            if (kind == 2) chk("grant_store", bus.ramstore, dat);
         end
         if (kind == 0 && !bus.dwait) other_ok = 1'b0;
         if (kind != 0 && !bus.iwait) other_ok = 1'b0;
         if ((kind == 0) ? !bus.iwait : !bus.dwait) begin
            acked = 1'b1;
            got = (kind == 0) ? bus.iload : bus.dload;
            bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
         end else if (scramble) begin
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
         end
      end
      chk("ack_seen", acked, 1'b1);
      chk("other_wait_high", other_ok, 1'b1);
      if (kind == 2) ref_mem[a[7:0]] = dat;
      else chk("read_data", got, ref_mem[a[7:0]]);
      bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      tick();
      chk("post_idle_en", {bus.ramREN, bus.ramWEN}, 2'b00);
      chk("post_idle_wait", {bus.iwait, bus.dwait}, 2'b11);
   endtask

   initial begin
      int    seen_i, seen_d;
      bit    got_ack;
      bit    no_pulse;
      word_t a, d;
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0;

      // reset
      RST = 1'b1;
      tick(); tick();
      chk("rst_waits", {bus.iwait, bus.dwait}, 2'b11);
      chk("rst_en", {bus.ramREN, bus.ramWEN}, 2'b00);
      chk("rst_addr", bus.ramaddr, 32'h0);
      chk("rst_loads", {bus.iload, bus.dload}, 64'h0);
      RST = 1'b0;
      tick();

      // write then readback
      lat = 1;
      do_txn(2, 32'hE0, 32'hBEEFDEAD, 1'b0);
      do_txn(1, 32'hE0, 32'h0, 1'b0);
      chk("readback_mem", mem[8'hE0], 32'hBEEFDEAD);
      do_txn(2, 32'h04, 32'h1234_5678, 1'b0);
      do_txn(0, 32'h04, 32'h0, 1'b0);

      // contention: every (DS+1)th grant goes to the icache
      bus.iREN = 1'b1; bus.iaddr = 32'h04;
      bus.dREN = 1'b1; bus.daddr = 32'hE0;
      for (int t = 0; t < 6; t++) begin
         got_ack = 1'b0;
         for (int c = 0; c < 20 && !got_ack; c++) begin
            tick();
            seen_i = !bus.iwait;
            seen_d = !bus.dwait;
            if (seen_i || seen_d) begin
               got_ack = 1'b1;
               chk("cont_not_both", seen_i & seen_d, 0);
               chk("cont_order_i", seen_i, ((t % (DS + 1)) == DS) ? 1 : 0);
               if (seen_i) chk("cont_iload", bus.iload, ref_mem[8'h04]);
               else        chk("cont_dload", bus.dload, ref_mem[8'hE0]);
               if (t == 5) begin bus.iREN = 1'b0; bus.dREN = 1'b0; end
            end
         end
         chk("cont_ack_seen", got_ack, 1'b1);
      end
      bus.iREN = 1'b0; bus.dREN = 1'b0;
      tick();

      // icache read abort while RAM stalled
      stall = 1'b1;
      bus.iREN = 1'b1; bus.iaddr = 32'h08;
      tick();
      chk("iabort_ren_on", bus.ramREN, 1'b1);
      no_pulse = bus.iwait;
      bus.iREN = 1'b0;
      tick();
      chk("iabort_ren_off", bus.ramREN, 1'b0);
      chk("iabort_no_ack", no_pulse & bus.iwait, 1'b1);

      // dcache write cannot be aborted
      bus.dWEN = 1'b1; bus.daddr = 32'h30; bus.dstore = 32'hCAFEF00D;
      tick();
      chk("wabort_wen_on", bus.ramWEN, 1'b1);
      bus.dWEN = 1'b0;
      tick();
      chk("wabort_wen_hold", bus.ramWEN, 1'b1);
      chk("wabort_wait_hold", bus.dwait, 1'b1);
      stall = 1'b0;
      #1;
      chk("wabort_ack", bus.dwait, 1'b0);
      ref_mem[8'h30] = 32'hCAFEF00D;
      tick();
      chk("wabort_idle", bus.ramWEN, 1'b0);
      do_txn(1, 32'h30, 32'h0, 1'b0);

      // ERROR holds the grant with no ack until RAM recovers
      force_err = 1'b1;
      bus.dREN = 1'b1; bus.daddr = 32'hE0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("err_hold", {bus.ramREN, bus.dwait}, 2'b11);
      end
      force_err = 1'b0;
      #1;
      chk("err_recover_ack", bus.dwait, 1'b0);
      chk("err_recover_data", bus.dload, ref_mem[8'hE0]);
      bus.dREN = 1'b0;
      tick();

      // reset in the middle of a stalled write
      stall = 1'b1;
      bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'h55;
      tick();
      chk("mrst_wen_on", bus.ramWEN, 1'b1);
      RST = 1'b1;
      tick();
      chk("mrst_en_off", {bus.ramREN, bus.ramWEN}, 2'b00);
      chk("mrst_wait", bus.dwait, 1'b1);
      chk("mrst_addr", bus.ramaddr, 32'h0);
      RST = 1'b0; bus.dWEN = 1'b0; stall = 1'b0;
      tick();
      do_txn(1, 32'h40, 32'h0, 1'b0);
      do_txn(1, 32'hE0, 32'h0, 1'b0);

      // randomized traffic against the reference memory
      for (int n = 0; n < 30; n++) begin
         lat = $urandom_range(0, 3);
         a = word_t'($urandom_range(0, 255));
         d = $urandom;
         do_txn($urandom_range(0, 2), a, d, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
